entropy_src_ht_window_ctrl: RTL and testbench
=============================================

Name: entropy_src_ht_window_ctrl

Overview:
- Health-test window controller, directly upstream of the entropy_src main state machine.
- Counts accepted RNG samples into fixed-size test windows and ORs the per-test fail flags at each window boundary.
- Produces the ht_done_pulse / ht_fail_pulse pair and the alert-threshold level the main FSM consumes.
- Maintains the consecutive-failure alert counter, which the main FSM clears via its rst_alert_cntr output.

Parameters:
- NumTests, 6, number of health tests whose fail flags are combined
- WinCntWidth, 16, width of window-size and sample counters
- AlertCntWidth, 16, width of alert and total-fail counters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  module enable; low forces Idle and clears window state
- window_size_i  in  WinCntWidth  samples per window; captured on Idle->Run
- sample_vld_i  in  1  one RNG sample accepted by the health tests this cycle
- test_fail_i  in  NumTests  per-test fail flags, sampled in the window-end cycle
- alert_thresh_i  in  AlertCntWidth  failing-window count that raises alert; 0 = alert disabled
- rst_alert_cntr_i  in  1  clear alert counter (from main FSM)
- test_clr_o  out  1  clear health-test accumulators (window start)
- ht_done_pulse_o  out  1  window complete
- ht_fail_pulse_o  out  1  completed window failed; only high with ht_done_pulse_o
- alert_thresh_fail_o  out  1  alert count reached threshold
- alert_cnt_o  out  AlertCntWidth  current alert count
- fail_total_o  out  AlertCntWidth  saturating total of failed windows since reset
- window_cnt_o  out  WinCntWidth  samples in the current window
- cfg_err_o  out  1  window_size_i == 0 at start

Behaviour:
- Reset: state=Idle; all counters 0; all outputs 0. Only rst_i clears fail_total_o.
- Idle:
  - window_cnt=0; window_size_q is not loaded; pulses stay 0.
  - On enable_i, capture window_size_q=window_size_i and pulse test_clr_o for 1 cycle.
  - If window_size_i==0, go to CfgErr; otherwise go to Run.
- Run:
  - Each sample_vld_i increments window_cnt.
  - Window end = sample_vld_i && window_cnt==window_size_q-1.
  - On window end:
    - window_cnt<=0 and test_fail_q<=|test_fail_i.
    - Next cycle: ht_done_pulse_o=1 and ht_fail_pulse_o=test_fail_q (latency exactly 1 cycle from the last sample); test_clr_o=1 in that same cycle.
  - Window size is not re-read until the next pass through Idle.
- CfgErr: cfg_err_o=1 as a level; no pulses. Exit to Idle on !enable_i.
- enable_i low in any state:
  - Next state Idle; window_cnt cleared; any pending done pulse is suppressed.
  - alert_cnt is held, not cleared.
- Alert counter:
  - alert_cnt updates on the same edge that raises ht_done_pulse_o, incrementing by 1 when the window failed.
  - Saturates at all-ones.
  - rst_alert_cntr_i clears it on the next edge.
  - If a failing-window increment and a clear land on the same edge, the result is 1 (clear then increment).
- fail_total: +1 per failed window, saturating; cleared only by rst_i.
- alert_thresh_fail_o = (alert_thresh_i!=0) && (alert_cnt_q >= alert_thresh_i). It is combinational from registers, so it is valid in the same cycle as ht_done_pulse_o.
- window_size_q==1: every accepted sample ends a window; back-to-back done pulses are legal.
- Any illegal FSM encoding forces CfgErr.

Decomposition:
- Package entropy_src_ht_window_pkg:
  - sparse state_e enum {Idle, Run, CfgErr};
  - StateWidth;
  - default width constants.
- One sub-module, entropy_src_sat_cntr (parameter Width; inputs clr, incr; clear-then-increment semantics). It is instantiated for alert_cnt and fail_total.

Test Plan:
- Window passes: window_size=4, enable, 4 sample_vld_i, test_fail_i=0 -> ht_done_pulse_o=1 exactly 1 cycle after the 4th sample; ht_fail_pulse_o=0; test_clr_o pulses at start and at that cycle.
- Window fails: window_size=4, test_fail_i=6'b000100 during the 4th sample -> ht_done_pulse_o=1 and ht_fail_pulse_o=1; alert_cnt_o=1; fail_total_o=1.
- Alert threshold: alert_thresh=2, two consecutive failing windows -> alert_thresh_fail_o=1 in the same cycle as the 2nd ht_done_pulse_o.
- Alert clear: rst_alert_cntr_i asserted in the done cycle -> alert_cnt_o=0 next cycle. Clear coincident with a failing increment -> alert_cnt_o=1.
- Enable drop mid-window: enable_i low after 2 of 4 samples -> no done pulse; window_cnt_o=0; re-enable with window_size=3 -> pulse after 3 samples.
- Config error and saturation:
  - window_size=0 -> cfg_err_o=1 and no pulses.
  - AlertCntWidth=2 with 5 failing windows -> alert_cnt_o holds at 3.

Source files
------------

// File: rtl/entropy_src_ht_window_pkg.sv
// Shared types and default widths for the entropy_src health-test window controller.
package entropy_src_ht_window_pkg;

  localparam int NumTestsDefault      = 6;
  localparam int WinCntWidthDefault   = 16;
  localparam int AlertCntWidthDefault = 16;

  // Sparse encoding: every legal pair differs in two bits, so a single upset lands illegal.
  localparam int StateWidth = 3;
  typedef enum logic [StateWidth-1:0] {
    Idle   = 3'b101,
    Run    = 3'b011,
    CfgErr = 3'b110
  } state_e;

endpackage

// File: rtl/entropy_src_sat_cntr.sv
// Saturating up-counter with clear-then-increment semantics on a single edge.
module entropy_src_sat_cntr #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             incr_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (incr_i && (cnt_d != {Width{1'b1}})) begin
      cnt_d = cnt_d + One;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/entropy_src_ht_window_ctrl.sv
// Health-test window controller: counts samples into windows, emits done/fail pulses
// one cycle after the last sample, and tracks alert and total failing-window counts.
module entropy_src_ht_window_ctrl
  import entropy_src_ht_window_pkg::*;
#(
  parameter int NumTests      = NumTestsDefault,
  parameter int WinCntWidth   = WinCntWidthDefault,
  parameter int AlertCntWidth = AlertCntWidthDefault
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [WinCntWidth-1:0]   window_size_i,
  input  logic                     sample_vld_i,
  input  logic [NumTests-1:0]      test_fail_i,
  input  logic [AlertCntWidth-1:0] alert_thresh_i,
  input  logic                     rst_alert_cntr_i,
  output logic                     test_clr_o,
  output logic                     ht_done_pulse_o,
  output logic                     ht_fail_pulse_o,
  output logic                     alert_thresh_fail_o,
  output logic [AlertCntWidth-1:0] alert_cnt_o,
  output logic [AlertCntWidth-1:0] fail_total_o,
  output logic [WinCntWidth-1:0]   window_cnt_o,
  output logic                     cfg_err_o
);

  localparam logic [WinCntWidth-1:0] WinOne = WinCntWidth'(1);

  state_e                 state_q;
  logic [WinCntWidth-1:0] window_size_q, window_cnt_q;
  logic                   done_q, fail_q, clr_q, cfg_err_q;
  logic                   window_end, fail_incr;

  // A window closes on the accepted sample that fills it; enable low swallows it.
  assign window_end = enable_i && (state_q == Run) && sample_vld_i &&
                      (window_cnt_q == (window_size_q - WinOne));
  assign fail_incr  = window_end && (|test_fail_i);

  always_ff @(posedge clk_i) begin
    if ((state_q == Idle) && enable_i) begin
      window_size_q <= window_size_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      window_cnt_q <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      clr_q        <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      clr_q  <= 1'b0;
      case (state_q)
        Idle: begin
          window_cnt_q <= '0;
          if (enable_i) begin
            clr_q <= 1'b1;
            if (window_size_i == '0) begin
              state_q   <= CfgErr;
              cfg_err_q <= 1'b1;
            end else begin
              state_q <= Run;
            end
          end
        end
        Run: begin
          if (!enable_i) begin
            state_q      <= Idle;
            window_cnt_q <= '0;
          end else if (window_end) begin
            window_cnt_q <= '0;
            done_q       <= 1'b1;
            fail_q       <= |test_fail_i;
            clr_q        <= 1'b1;
          end else if (sample_vld_i) begin
            window_cnt_q <= window_cnt_q + WinOne;
          end
        end
        CfgErr: begin
          if (!enable_i) begin
            state_q   <= Idle;
            cfg_err_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= CfgErr;
          cfg_err_q    <= 1'b1;
          window_cnt_q <= '0;
        end
      endcase
    end
  end

  entropy_src_sat_cntr #(
    .Width (AlertCntWidth)
  ) u_alert_cntr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (rst_alert_cntr_i),
    .incr_i (fail_incr),
    .cnt_o  (alert_cnt_o)
  );

  entropy_src_sat_cntr #(
    .Width (AlertCntWidth)
  ) u_fail_total_cntr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (1'b0),
    .incr_i (fail_incr),
    .cnt_o  (fail_total_o)
  );

  assign alert_thresh_fail_o = (alert_thresh_i != '0) && (alert_cnt_o >= alert_thresh_i);

  assign test_clr_o      = clr_q;
  assign ht_done_pulse_o = done_q;
  assign ht_fail_pulse_o = fail_q;
  assign window_cnt_o    = window_cnt_q;
  assign cfg_err_o       = cfg_err_q;

endmodule

// File: tb/tb_entropy_src_ht_window_ctrl.sv
// Bench for entropy_src_ht_window_ctrl: directed scenarios plus a randomized run against a sample-counting reference.
module tb_entropy_src_ht_window_ctrl;

  localparam int NT  = 6;
  localparam int WW  = 16;
  localparam int AW  = 16;
  localparam int AW2 = 2;
  localparam int AMAX  = 65535;
  localparam int AMAX2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, sv, rac;
  logic [WW-1:0] ws;
  logic [NT-1:0] tf;
  logic [AW-1:0] thr;

  logic           clr, done, fail, tfail, cfg;
  logic [AW-1:0]  alert, total;
  logic [WW-1:0]  wcnt;
  logic           clr2, done2, fail2, tfail2, cfg2;
  logic [AW2-1:0] alert2, total2;
  logic [WW-1:0]  wcnt2;

  int checks = 0;
  int errors = 0;

  // Reference state: mode 0 idle, 1 running, 2 config error; cnt = samples seen in this window.
  int m_mode = 0, m_size = 0, m_cnt = 0;
  int m_alert = 0, m_alert2 = 0, m_total = 0, m_total2 = 0;
  bit m_done = 0, m_fail = 0, m_clr = 0, m_cfg = 0;

  entropy_src_ht_window_ctrl #(.NumTests(NT), .WinCntWidth(WW), .AlertCntWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .window_size_i(ws), .sample_vld_i(sv),
    .test_fail_i(tf), .alert_thresh_i(thr), .rst_alert_cntr_i(rac),
    .test_clr_o(clr), .ht_done_pulse_o(done), .ht_fail_pulse_o(fail),
    .alert_thresh_fail_o(tfail), .alert_cnt_o(alert), .fail_total_o(total),
    .window_cnt_o(wcnt), .cfg_err_o(cfg)
  );

  entropy_src_ht_window_ctrl #(.NumTests(NT), .WinCntWidth(WW), .AlertCntWidth(AW2)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .window_size_i(ws), .sample_vld_i(sv),
    .test_fail_i(tf), .alert_thresh_i(thr[AW2-1:0]), .rst_alert_cntr_i(rac),
    .test_clr_o(clr2), .ht_done_pulse_o(done2), .ht_fail_pulse_o(fail2),
    .alert_thresh_fail_o(tfail2), .alert_cnt_o(alert2), .fail_total_o(total2),
    .window_cnt_o(wcnt2), .cfg_err_o(cfg2)
  );

  // Advance reference by one clock from the inputs currently applied, then clock the DUTs.
  task automatic step();
    bit nd, nf, nc;
    nd = 0; nf = 0; nc = 0;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_cfg = 0;
      m_alert = 0; m_alert2 = 0; m_total = 0; m_total2 = 0;
    end else begin
      if (!en) begin
        m_mode = 0; m_cnt = 0; m_cfg = 0;
      end else if (m_mode == 0) begin
        m_size = int'(ws);
        nc = 1;
        if (m_size == 0) begin m_mode = 2; m_cfg = 1; end
        else m_mode = 1;
      end else if (m_mode == 1 && sv) begin
        m_cnt++;
        if (m_cnt == m_size) begin
          m_cnt = 0; nd = 1; nf = (tf != '0); nc = 1;
        end
      end
      if (rac) begin m_alert = 0; m_alert2 = 0; end
      if (nd && nf) begin
        if (m_alert < AMAX) m_alert++;
        if (m_alert2 < AMAX2) m_alert2++;
        if (m_total < AMAX) m_total++;
        if (m_total2 < AMAX2) m_total2++;
      end
    end
    m_done = nd; m_fail = nf; m_clr = nc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sv = 1'b0; rac = 1'b0; ws = '0; tf = '0; thr = '0;
    step(); step();
    checks++; if ({done, fail, clr, cfg, tfail} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {done, fail, clr, cfg, tfail}); end
    checks++; if (alert !== '0 || total !== '0) begin errors++; $display("FAIL reset_counts got alert %0d total %0d exp 0 0", alert, total); end
    checks++; if (wcnt !== '0 || alert2 !== '0) begin errors++; $display("FAIL reset_wcnt got %0d alert2 %0d exp 0 0", wcnt, alert2); end
    rst = 1'b0;
    step();
    checks++; if ({done, clr, cfg} !== 3'b0) begin errors++; $display("FAIL idle_quiet got %b exp 000", {done, clr, cfg}); end
  endtask

  task automatic test_window_pass();
    ws = WW'(4); en = 1'b1;
    step();
    checks++; if (clr !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL pass_start got clr %b done %b exp 1 0", clr, done); end
    for (int i = 0; i < 4; i++) begin
      sv = 1'b1; tf = '0;
      step();
      checks++; if (done !== (i == 3)) begin errors++; $display("FAIL pass_done[%0d] got %b exp %b", i, done, (i == 3)); end
      checks++; if (wcnt !== WW'((i + 1) % 4)) begin errors++; $display("FAIL pass_wcnt[%0d] got %0d exp %0d", i, wcnt, (i + 1) % 4); end
    end
    checks++; if (fail !== 1'b0 || clr !== 1'b1) begin errors++; $display("FAIL pass_end got fail %b clr %b exp 0 1", fail, clr); end
    sv = 1'b0;
    step();
    checks++; if (done !== 1'b0 || clr !== 1'b0) begin errors++; $display("FAIL pass_after got done %b clr %b exp 0 0", done, clr); end
  endtask

  task automatic test_window_fail();
    for (int i = 0; i < 4; i++) begin
      sv = 1'b1; tf = (i == 3) ? NT'(6'b000100) : '0;
      step();
    end
    checks++; if (done !== 1'b1 || fail !== 1'b1) begin errors++; $display("FAIL fail_pulse got done %b fail %b exp 1 1", done, fail); end
    checks++; if (alert !== AW'(1) || total !== AW'(1)) begin errors++; $display("FAIL fail_counts got alert %0d total %0d exp 1 1", alert, total); end
    sv = 1'b0; tf = '0;
    step();
  endtask

  task automatic test_alert_thresh();
    rac = 1'b1; step(); rac = 1'b0;
    thr = AW'(2);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        sv = 1'b1; tf = (i == 3) ? NT'($urandom_range(1, 63)) : '0;
        step();
      end
      checks++; if (done !== 1'b1 || tfail !== (w == 1)) begin errors++; $display("FAIL thresh[%0d] got done %b tfail %b exp 1 %b", w, done, tfail, (w == 1)); end
    end
    sv = 1'b0; tf = '0;
  endtask

  task automatic test_alert_clear();
    rac = 1'b1; step(); rac = 1'b0;
    checks++; if (alert !== '0 || tfail !== 1'b0) begin errors++; $display("FAIL clr_alert got %0d tfail %b exp 0 0", alert, tfail); end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        sv = 1'b1; tf = (i == 3) ? NT'(6'b100000) : '0;
        rac = (w == 1 && i == 3);
        step();
      end
      checks++; if (alert !== AW'(1)) begin errors++; $display("FAIL clr_incr[%0d] got %0d exp 1", w, alert); end
    end
    checks++; if (total !== AW'(5)) begin errors++; $display("FAIL clr_total got %0d exp 5", total); end
    rac = 1'b0; sv = 1'b0; tf = '0;
    step();
  endtask

  task automatic test_enable_drop();
    en = 1'b0; step();
    ws = WW'(4); en = 1'b1; step();
    sv = 1'b1; step(); step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (done !== 1'b0 || wcnt !== '0) begin errors++; $display("FAIL drop[%0d] got done %b wcnt %0d exp 0 0", i, done, wcnt); end
    end
    checks++; if (alert !== AW'(1)) begin errors++; $display("FAIL drop_alert_held got %0d exp 1", alert); end
    sv = 1'b0; ws = WW'(3); en = 1'b1; step();
    sv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (done !== (i == 2)) begin errors++; $display("FAIL reen_done[%0d] got %b exp %b", i, done, (i == 2)); end
    end
    sv = 1'b0; step();
  endtask

  task automatic test_cfg_err();
    en = 1'b0; step();
    ws = '0; en = 1'b1; step();
    checks++; if (cfg !== 1'b1) begin errors++; $display("FAIL cfg_set got %b exp 1", cfg); end
    sv = 1'b1; tf = NT'(6'b111111);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({cfg, done, fail} !== 3'b100) begin errors++; $display("FAIL cfg_hold[%0d] got %b exp 100", i, {cfg, done, fail}); end
    end
    en = 1'b0; sv = 1'b0; tf = '0; step();
    checks++; if (cfg !== 1'b0) begin errors++; $display("FAIL cfg_exit got %b exp 0", cfg); end
  endtask

  task automatic test_back_to_back_sat();
    rac = 1'b1; step(); rac = 1'b0;
    ws = WW'(1); en = 1'b1; step();
    sv = 1'b1; tf = NT'(6'b000001);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (done !== 1'b1 || fail !== 1'b1) begin errors++; $display("FAIL b2b[%0d] got done %b fail %b exp 1 1", i, done, fail); end
      checks++; if (alert !== AW'(i + 1) || alert2 !== AW2'((i + 1 > 3) ? 3 : i + 1)) begin
        errors++; $display("FAIL sat[%0d] got alert %0d alert2 %0d exp %0d %0d", i, alert, alert2, i + 1, (i + 1 > 3) ? 3 : i + 1); end
    end
    checks++; if (total !== AW'(10) || total2 !== AW2'(3)) begin errors++; $display("FAIL sat_total got %0d %0d exp 10 3", total, total2); end
    sv = 1'b0; tf = '0; step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 19) != 0);
      ws  = WW'($urandom_range(0, 5));
      sv  = ($urandom_range(0, 2) != 0);
      tf  = ($urandom_range(0, 2) == 0) ? NT'($urandom_range(1, 63)) : '0;
      rac = ($urandom_range(0, 15) == 0);
      thr = AW'($urandom_range(0, 4));
      step();
      checks++; if ({done, fail, clr, cfg} !== {m_done, m_fail, m_clr, m_cfg}) begin
        errors++; $display("FAIL rnd_flags[%0d] got %b exp %b", c, {done, fail, clr, cfg}, {m_done, m_fail, m_clr, m_cfg}); end
      checks++; if (wcnt !== WW'(m_cnt) || wcnt2 !== WW'(m_cnt)) begin
        errors++; $display("FAIL rnd_wcnt[%0d] got %0d %0d exp %0d", c, wcnt, wcnt2, m_cnt); end
      checks++; if (alert !== AW'(m_alert) || total !== AW'(m_total)) begin
        errors++; $display("FAIL rnd_cnt[%0d] got %0d %0d exp %0d %0d", c, alert, total, m_alert, m_total); end
      checks++; if (alert2 !== AW2'(m_alert2) || total2 !== AW2'(m_total2)) begin
        errors++; $display("FAIL rnd_cnt2[%0d] got %0d %0d exp %0d %0d", c, alert2, total2, m_alert2, m_total2); end
      checks++; if (tfail !== (thr != 0 && m_alert >= int'(thr)) || tfail2 !== (thr[1:0] != 0 && m_alert2 >= int'(thr[1:0]))) begin
        errors++; $display("FAIL rnd_thresh[%0d] got %b %b exp alert %0d thr %0d", c, tfail, tfail2, m_alert, thr); end
      checks++; if ({done2, fail2, clr2, cfg2} !== {m_done, m_fail, m_clr, m_cfg}) begin
        errors++; $display("FAIL rnd_flags2[%0d] got %b exp %b", c, {done2, fail2, clr2, cfg2}, {m_done, m_fail, m_clr, m_cfg}); end
    end
  endtask

  initial begin
    test_reset();
    test_window_pass();
    test_window_fail();
    test_alert_thresh();
    test_alert_clear();
    test_enable_drop();
    test_cfg_err();
    test_back_to_back_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
